rcv_coeff_ctrl: RTL and testbench

Coefficient configuration controller for the 21-tap symmetric receive filter (11 unique 0s18 coefficients). A host writes a new coefficient set into a shadow bank through a valid/ready port. On commit, the block swaps the shadow bank into the active bank on the next filter sample boundary, so the datapath never multiplies with a mixed set. It also provides the team's debug coefficient patterns (impulse, flat 1/16, zero) and registered readback.

---
 rtl/rcv_coeff_ctrl.sv | 128 ++++++++++++
 tb/tb_rcv_coeff_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rcv_coeff_ctrl.sv
// Coefficient bank controller for the 21-tap symmetric receive filter.
// Host writes a shadow bank; commit swaps it into the active bank on the next sample boundary.
//
// state | meaning
// IDLE  | accepting host writes; commit with a dirty shadow moves to PEND
// PEND  | swap requested; waiting for samp_en, writes are stalled
module rcv_coeff_ctrl #(
    parameter int NTAPS = 11,
    parameter int CW    = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  samp_en,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [3:0]            wr_addr,
    input  logic [CW-1:0]         wr_data,
    input  logic                  commit,
    input  logic [1:0]            mode,
    input  logic [3:0]            rd_addr,
    input  logic                  rd_sel,
    output logic [CW-1:0]         rd_data,
    output logic [NTAPS*CW-1:0]   coef_flat,
    output logic                  busy,
    output logic                  swap_done,
    output logic                  err
);

    typedef enum logic {IDLE, PEND} state_t;

    localparam logic [3:0]    NTAPS_A  = 4'(NTAPS);
    localparam logic [CW-1:0] IMPULSE  = {1'b0, {(CW-1){1'b1}}};
    localparam logic [CW-1:0] FLAT_VAL = CW'(8192);

    state_t               state, state_nxt;
    logic [CW-1:0]        shadow [NTAPS];
    logic [CW-1:0]        active [NTAPS];
    logic                 dirty;
    logic [1:0]           mode_q;
    logic                 wr_acc, wr_hit, do_swap, err_set;
    logic [NTAPS*CW-1:0]  coef_nxt;

    always_comb begin
        state_nxt = state;
        wr_ready  = 1'b0;
        busy      = 1'b0;
        do_swap   = 1'b0;
        wr_acc    = 1'b0;
        wr_hit    = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                wr_acc   = wr_valid;
                wr_hit   = wr_valid && (wr_addr < NTAPS_A);
                if (wr_acc && !wr_hit)
                    err_set = 1'b1;
                // a write on the commit cycle belongs to the committed set
                if (commit) begin
                    if (dirty || wr_hit)
                        state_nxt = PEND;
                    else
                        err_set = 1'b1;
                end
            end
            PEND: begin
                busy = 1'b1;
                if (samp_en) begin
                    do_swap   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Pattern is built from the post-swap active bank and the mode being captured.
    always_comb begin
        coef_nxt = '0;
        for (int i = 0; i < NTAPS; i++) begin
            case (mode)
                2'd0: coef_nxt[i*CW +: CW] = do_swap ? shadow[i] : active[i];
                2'd1: coef_nxt[i*CW +: CW] = (i == NTAPS-1) ? IMPULSE : '0;
                2'd2: coef_nxt[i*CW +: CW] = FLAT_VAL;
                default: coef_nxt[i*CW +: CW] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dirty     <= 1'b0;
            mode_q    <= 2'd0;
            swap_done <= 1'b0;
            err       <= 1'b0;
            rd_data   <= '0;
            coef_flat <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            swap_done <= do_swap;
            if (err_set)
                err <= 1'b1;
            if (wr_hit) begin
                shadow[wr_addr] <= wr_data;
                dirty           <= 1'b1;
            end
            if (do_swap) begin
                for (int i = 0; i < NTAPS; i++)
                    active[i] <= shadow[i];
                dirty <= 1'b0;
            end
            if (samp_en) begin
                mode_q    <= mode;
                coef_flat <= coef_nxt;
            end
            if (rd_addr < NTAPS_A)
                rd_data <= rd_sel ? shadow[rd_addr] : active[rd_addr];
            else
                rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_rcv_coeff_ctrl.sv
// Directed self-checking bench for rcv_coeff_ctrl: swap timing, stalls, errors, modes, reset.
module tb_rcv_coeff_ctrl;

    localparam int NTAPS = 11;
    localparam int CW    = 18;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 samp_en = 1'b0;
    logic                 wr_valid = 1'b0;
    logic                 wr_ready;
    logic [3:0]           wr_addr = '0;
    logic [CW-1:0]        wr_data = '0;
    logic                 commit = 1'b0;
    logic [1:0]           mode = '0;
    logic [3:0]           rd_addr = '0;
    logic                 rd_sel = 1'b0;
    logic [CW-1:0]        rd_data;
    logic [NTAPS*CW-1:0]  coef_flat;
    logic                 busy, swap_done, err;

    int n_pass  = 0;
    int n_total = 0;
    int exp_b [NTAPS];

    rcv_coeff_ctrl #(.NTAPS(NTAPS), .CW(CW)) dut (
        .clk(clk), .reset(reset), .samp_en(samp_en), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .mode(mode), .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data),
        .coef_flat(coef_flat), .busy(busy), .swap_done(swap_done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [NTAPS*CW-1:0] pack_exp();
        logic [NTAPS*CW-1:0] r;
        r = '0;
        for (int i = 0; i < NTAPS; i++)
            r[i*CW +: CW] = CW'(exp_b[i]);
        return r;
    endfunction

    // inputs change at negedge; one tick consumes one rising edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write(input int addr, input int val);
        wr_valid = 1'b1; wr_addr = 4'(addr); wr_data = CW'(val);
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic pulse_samp();
        samp_en = 1'b1;
        tick();
        samp_en = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (wr_ready !== 1'b1) $display("FAIL rst_wr_ready got %0b exp 1", wr_ready); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b exp 0", busy); else n_pass++;
        n_total++; if (coef_flat !== '0) $display("FAIL rst_coef got %h exp 0", coef_flat); else n_pass++;
        n_total++; if (rd_data !== '0 || swap_done !== 1'b0) $display("FAIL rst_rd_swap got %h/%0b exp 0/0", rd_data, swap_done); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        tick();
        pulse_samp();
        n_total++; if (coef_flat !== '0) $display("FAIL samp_coef_zero got %h exp 0", coef_flat); else n_pass++;
        n_total++; if (err !== 1'b0 || wr_ready !== 1'b1) $display("FAIL samp_err_rdy got %0b/%0b exp 0/1", err, wr_ready); else n_pass++;
    endtask

    task automatic test_swap();
        int busy_cnt;
        exp_b = '{2817, 4060, 2289, -2373, -7348, -8574, -2772, 10263, 26830, 40696, 46096};
        for (int i = 0; i < NTAPS; i++)
            write(i, exp_b[i]);
        rd_sel = 1'b1; rd_addr = 4'd7;
        tick();
        n_total++; if (rd_data !== CW'(10263)) $display("FAIL shadow_rd7 got %0d exp 10263", $signed(rd_data)); else n_pass++;
        rd_sel = 1'b0;
        tick();
        n_total++; if (rd_data !== '0) $display("FAIL active_rd7_pre got %0d exp 0", $signed(rd_data)); else n_pass++;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        busy_cnt = 0;
        if (busy === 1'b1) busy_cnt++;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
        end
        n_total++; if (coef_flat !== '0 || wr_ready !== 1'b0) $display("FAIL pend_hold got coef %h rdy %0b exp 0/0", coef_flat, wr_ready); else n_pass++;
        pulse_samp();
        n_total++; if (busy_cnt != 5) $display("FAIL busy_len got %0d exp 5", busy_cnt); else n_pass++;
        n_total++; if (coef_flat !== pack_exp()) $display("FAIL swap_coef got %h exp %h", coef_flat, pack_exp()); else n_pass++;
        n_total++; if (swap_done !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1) $display("FAIL swap_flags got %0b%0b%0b exp 101", swap_done, busy, wr_ready); else n_pass++;
        tick();
        n_total++; if (swap_done !== 1'b0) $display("FAIL swap_pulse got %0b exp 0", swap_done); else n_pass++;
        n_total++; if (coef_flat !== pack_exp()) $display("FAIL coef_hold got %h exp %h", coef_flat, pack_exp()); else n_pass++;
    endtask

    task automatic test_pend_write();
        write(0, 2817);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = CW'(999);
        rd_sel = 1'b1; rd_addr = 4'd3;
        tick();
        n_total++; if (wr_ready !== 1'b0 || busy !== 1'b1) $display("FAIL pend_stall got rdy %0b busy %0b exp 0/1", wr_ready, busy); else n_pass++;
        tick();
        n_total++; if (rd_data !== CW'(-2373)) $display("FAIL pend_no_write got %0d exp -2373", $signed(rd_data)); else n_pass++;
        pulse_samp();
        tick();
        wr_valid = 1'b0;
        n_total++; if (err !== 1'b0) $display("FAIL pend_no_err got %0b exp 0", err); else n_pass++;
        rd_sel = 1'b0;
        tick();
        n_total++; if (rd_data !== CW'(-2373)) $display("FAIL active_b3 got %0d exp -2373", $signed(rd_data)); else n_pass++;
        rd_sel = 1'b1;
        tick();
        n_total++; if (rd_data !== CW'(999)) $display("FAIL shadow_b3 got %0d exp 999", $signed(rd_data)); else n_pass++;
    endtask

    task automatic test_err();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        pulse_samp();
        exp_b[3] = 999;
        n_total++; if (coef_flat !== pack_exp()) $display("FAIL swap2_coef got %h exp %h", coef_flat, pack_exp()); else n_pass++;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_total++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL clean_commit got err %0b busy %0b exp 1/0", err, busy); else n_pass++;
        pulse_samp();
        n_total++; if (swap_done !== 1'b0) $display("FAIL clean_no_swap got %0b exp 0", swap_done); else n_pass++;
        write(12, 77);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_total++; if (busy !== 1'b0 || err !== 1'b1) $display("FAIL badaddr_dirty got busy %0b err %0b exp 0/1", busy, err); else n_pass++;
        rd_sel = 1'b1; rd_addr = 4'd1;
        tick();
        n_total++; if (rd_data !== CW'(4060)) $display("FAIL badaddr_alias got %0d exp 4060", $signed(rd_data)); else n_pass++;
        rd_addr = 4'd12;
        tick();
        n_total++; if (rd_data !== '0) $display("FAIL rd_oob got %0d exp 0", $signed(rd_data)); else n_pass++;
    endtask

    task automatic test_mode();
        logic [NTAPS*CW-1:0] e;
        mode = 2'd1;
        tick();
        n_total++; if (coef_flat !== pack_exp()) $display("FAIL mode_no_samp got %h exp %h", coef_flat, pack_exp()); else n_pass++;
        pulse_samp();
        e = '0; e[(NTAPS-1)*CW +: CW] = CW'(131071);
        n_total++; if (coef_flat !== e) $display("FAIL mode_impulse got %h exp %h", coef_flat, e); else n_pass++;
        mode = 2'd2;
        pulse_samp();
        for (int i = 0; i < NTAPS; i++) e[i*CW +: CW] = CW'(8192);
        n_total++; if (coef_flat !== e) $display("FAIL mode_flat got %h exp %h", coef_flat, e); else n_pass++;
        mode = 2'd3;
        pulse_samp();
        n_total++; if (coef_flat !== '0) $display("FAIL mode_zero got %h exp 0", coef_flat); else n_pass++;
        mode = 2'd0;
        pulse_samp();
        n_total++; if (coef_flat !== pack_exp()) $display("FAIL mode_normal got %h exp %h", coef_flat, pack_exp()); else n_pass++;
    endtask

    task automatic test_commit_samp_same();
        logic [NTAPS*CW-1:0] old_e;
        old_e = pack_exp();
        write(5, -1);
        commit = 1'b1; samp_en = 1'b1;
        tick();
        commit = 1'b0; samp_en = 1'b0;
        n_total++; if (busy !== 1'b1 || swap_done !== 1'b0) $display("FAIL same_cycle got busy %0b swap %0b exp 1/0", busy, swap_done); else n_pass++;
        n_total++; if (coef_flat !== old_e) $display("FAIL same_cycle_coef got %h exp %h", coef_flat, old_e); else n_pass++;
        tick();
        tick();
        pulse_samp();
        exp_b[5] = -1;
        n_total++; if (swap_done !== 1'b1 || coef_flat !== pack_exp()) $display("FAIL second_samp got swap %0b coef %h exp 1 %h", swap_done, coef_flat, pack_exp()); else n_pass++;
    endtask

    task automatic test_reset_pend();
        write(0, 123);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL pend2_busy got %0b exp 1", busy); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0 || coef_flat !== '0) $display("FAIL async_rst got busy %0b coef %h exp 0/0", busy, coef_flat); else n_pass++;
        n_total++; if (err !== 1'b0 || wr_ready !== 1'b1) $display("FAIL async_rst_flags got err %0b rdy %0b exp 0/1", err, wr_ready); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        rd_sel = 1'b1; rd_addr = 4'd0;
        tick();
        n_total++; if (rd_data !== '0) $display("FAIL rst_shadow_clr got %0d exp 0", $signed(rd_data)); else n_pass++;
        pulse_samp();
        n_total++; if (swap_done !== 1'b0 || coef_flat !== '0) $display("FAIL rst_abandon got swap %0b coef %h exp 0/0", swap_done, coef_flat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_swap();
        test_pend_write();
        test_err();
        test_mode();
        test_commit_samp_same();
        test_reset_pend();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
